move_scheduler: RTL

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/quidditch_pkg.sv | 27 ++
 rtl/button_edge_sync.sv | 33 +++
 rtl/move_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/quidditch_pkg.sv
// Shared game-state encodings and speed-code constants for the move scheduler.
package quidditch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_FREEZE = 2'd3
    } game_state_e;

    localparam logic [1:0] SPD_EVERY   = 2'd0;
    localparam logic [1:0] SPD_HALF    = 2'd1;
    localparam logic [1:0] SPD_QUARTER = 2'd2;
    localparam logic [1:0] SPD_NEVER   = 2'd3;

    // True when a player with this speed code moves in the given round.
    function automatic logic speed_due(input logic [1:0] code, input logic [1:0] round);
        case (code)
            SPD_EVERY:   speed_due = 1'b1;
            SPD_HALF:    speed_due = ~round[0];
            SPD_QUARTER: speed_due = (round == 2'd0);
            SPD_NEVER:   speed_due = 1'b0;
            default:     speed_due = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer for an active-low push button with a one-cycle press strobe.
module button_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic button_n_i,
    output logic event_o
);

    logic       sync1_q, sync2_q, prev_q, armed_q;
    logic [1:0] fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= button_n_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            // A button held through reset must be seen released before it can fire.
            if (fill_q[1] && sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign event_o = armed_q & prev_q & ~sync2_q;

endmodule

// File: rtl/move_scheduler.sv
// Game-state FSM with a tick prescaler that round-robins move strobes across players.
module move_scheduler
    import quidditch_pkg::*;
#(
    parameter int NUM_PLAYERS  = 4,
    parameter int TICK_DIV     = 100000,
    parameter int FREEZE_TICKS = 2000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_button,
    input  logic                     pause_button,
    input  logic                     goal_event,
    input  logic [2*NUM_PLAYERS-1:0] speed_sel,
    output logic [NUM_PLAYERS-1:0]   move_en,
    output logic [1:0]               game_state,
    output logic                     base_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int FW = $clog2(FREEZE_TICKS + 1);

    game_state_e            state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [1:0]             round_q, round_d;
    logic [FW-1:0]          freeze_q, freeze_d;
    logic [NUM_PLAYERS-1:0] move_q, move_d;
    logic                   start_evt, pause_evt, tick, serve;

    button_edge_sync u_start_sync (
        .clk        (clk),
        .rst        (rst),
        .button_n_i (start_button),
        .event_o    (start_evt)
    );

    button_edge_sync u_pause_sync (
        .clk        (clk),
        .rst        (rst),
        .button_n_i (pause_button),
        .event_o    (pause_evt)
    );

    always_comb begin
        tick     = ((state_q == ST_PLAY) || (state_q == ST_FREEZE)) && (presc_q == PW'(TICK_DIV - 1));
        state_d  = state_q;
        presc_d  = presc_q;
        slot_d   = slot_q;
        round_d  = round_q;
        freeze_d = freeze_q;
        move_d   = '0;

        case (state_q)
            ST_IDLE:   if (start_evt) state_d = ST_PLAY;
            ST_PLAY: begin
                // A goal wins over a simultaneous pause; the pause is dropped.
                if (goal_event)     state_d = ST_FREEZE;
                else if (pause_evt) state_d = ST_PAUSE;
            end
            ST_PAUSE:  if (pause_evt) state_d = ST_PLAY;
            ST_FREEZE: if (tick && (freeze_q == FW'(FREEZE_TICKS - 1))) state_d = ST_PLAY;
            default:   state_d = ST_IDLE;
        endcase

        // A tick in the cycle that leaves PLAY serves nobody, so the slot is retried on resume.
        serve = tick && (state_q == ST_PLAY) && (state_d == ST_PLAY);

        if (state_q == ST_IDLE) begin
            presc_d = '0;
        end else if (state_q != ST_PAUSE) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (state_q == ST_IDLE) begin
            slot_d  = '0;
            round_d = '0;
        end else if (serve) begin
            if (slot_q == SW'(NUM_PLAYERS - 1)) begin
                slot_d  = '0;
                round_d = round_q + 2'd1;
            end else begin
                slot_d = slot_q + SW'(1);
            end
        end

        if (state_q != ST_FREEZE) begin
            freeze_d = '0;
        end else if (tick) begin
            freeze_d = freeze_q + FW'(1);
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (serve && (slot_q == SW'(i)) && speed_due(speed_sel[2*i +: 2], round_q)) begin
                move_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            slot_q   <= '0;
            round_q  <= '0;
            freeze_q <= '0;
            move_q   <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            slot_q   <= slot_d;
            round_q  <= round_d;
            freeze_q <= freeze_d;
            move_q   <= move_d;
        end
    end

    assign move_en    = move_q;
    assign game_state = state_q;
    assign base_tick  = tick;

endmodule
